store_commit_buffer: RTL and testbench
======================================

STORE_COMMIT_BUFFER -- requirements
Module: store_commit_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning entry count (power of 2, equal to ROB depth).
REQ-002 SHALL have parameter TAG_W, default 4, meaning ROB tag width (log2 DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have st_valid/st_tag/st_addr/st_data, input, 1/TAG_W/32/32 bits: store ready from mem reservation station.
REQ-006 SHALL have st_ready, output, 1 bit: =!full; store accepted when st_valid&st_ready.
REQ-007 SHALL have commit_valid/commit_tag, input, 1/TAG_W bits: ROB retiring a store with this tag.
REQ-008 SHALL have flush, input, 1 bit: branch mispredict flush.
REQ-009 SHALL have mem_stall, input, 1 bit: memory stage stall.
REQ-010 SHALL have mem_wr_en/mem_wr_addr/mem_wr_data, output, 1/32/32 bits: store write toward d-cache.
REQ-011 SHALL have ld_check_addr, input, 32 bits, and ld_addr_hit, output, 1 bit: load-vs-pending-store address check.
REQ-012 SHALL have full, empty, output, 1 bit each; count, output, TAG_W+1 bits; commit_miss, output, 1 bit.

Function
REQ-013 SHALL hold an in-order circular queue; each entry: valid, committed, tag, addr, data; wr_ptr/rd_ptr TAG_W+1 bits, wrap modulo 2*DEPTH.
REQ-014 SHALL define empty = wr_ptr==rd_ptr; full = low bits equal and MSBs differ; count = wr_ptr-rd_ptr.
REQ-015 On st_valid&!full&!flush SHALL write entry at wr_ptr (valid=1, committed=0) and increment wr_ptr; st_valid while full SHALL be dropped, no state change.
REQ-016 On commit_valid SHALL set committed=1 on the valid, uncommitted entry whose tag==commit_tag; if none matches, commit_miss SHALL pulse high that same cycle (combinational), no state change.
REQ-017 If commit_valid and accepted st_valid carry the same tag in one cycle and no stored entry matches, the new entry SHALL be written with committed=1 and commit_miss=0.
REQ-018 mem_wr_en SHALL be combinational = head valid & head committed & !mem_stall; mem_wr_addr/mem_wr_data = head addr/data when mem_wr_en, else 0.
REQ-019 When mem_wr_en=1 the head SHALL be cleared and rd_ptr incremented at the clock edge; one store drained per cycle maximum.
REQ-020 Latency: store committed in cycle N SHALL produce mem_wr_en no earlier than N+1; store accepted in cycle N SHALL be drainable no earlier than N+1.
REQ-021 Enqueue and drain in the same cycle SHALL both occur; count unchanged; legal even when full (drain frees no slot for same-cycle enqueue; st_ready stays 0).
REQ-022 On flush SHALL invalidate all uncommitted entries and set wr_ptr to the first uncommitted position; committed entries (a head-contiguous prefix) SHALL be kept and continue draining.
REQ-023 Flush priority: same-cycle commit SHALL be applied before flush (entry survives); same-cycle enqueue SHALL be discarded; same-cycle drain SHALL proceed.
REQ-024 ld_addr_hit SHALL be combinational = OR over valid entries of (addr==ld_check_addr), full 32-bit compare, including committed-not-drained entries.
REQ-025 mem_stall SHALL freeze draining only; enqueue, commit and flush SHALL proceed during stall.

Reset
REQ-026 On rst_n=0 at a clock edge SHALL clear all entries, wr_ptr=rd_ptr=0; outputs: empty=1, full=0, count=0, st_ready=1, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, ld_addr_hit=0, commit_miss=0.
REQ-027 Reset mid-operation SHALL discard committed-but-undrained stores, with no mem_wr_en in the reset cycle or after.

Verification
REQ-028 Enqueue tag 3 addr 0x100 data 0xAA; commit tag 3 next cycle -> mem_wr_en=1, addr 0x100, data 0xAA one cycle later; empty=1 after.
REQ-029 Enqueue 16 stores -> full=1, st_ready=0, count=16; 17th st_valid dropped; commit+drain one -> count=15, st_ready=1.
REQ-030 Enqueue tags 1,2,3; commit 1,2; assert flush -> count=2, tag 3 gone, wr_ptr=rd_ptr+2; stores 1,2 drain in order.
REQ-031 Head committed, mem_stall=1 for 3 cycles -> mem_wr_en=0 throughout; store drains cycle mem_stall drops.
REQ-032 Pending store addr 0x200: ld_check_addr=0x200 -> ld_addr_hit=1; 0x204 -> 0; after drain, 0x200 -> 0.
REQ-033 commit_valid tag 7 with no tag-7 entry -> commit_miss=1 one cycle, queue unchanged; rst_n=0 with 4 committed entries -> empty=1, no writes issued.

Source files
------------

// File: rtl/store_commit_buffer.sv
// In-order store commit buffer between the memory reservation station and d-cache.
// Stores wait here until the ROB commits them, then drain one per cycle.
module store_commit_buffer #(
   parameter int DEPTH = 16,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             st_valid,
   input  logic [TAG_W-1:0] st_tag,
   input  logic [31:0]      st_addr,
   input  logic [31:0]      st_data,
   output logic             st_ready,
   input  logic             commit_valid,
   input  logic [TAG_W-1:0] commit_tag,
   input  logic             flush,
   input  logic             mem_stall,
   output logic             mem_wr_en,
   output logic [31:0]      mem_wr_addr,
   output logic [31:0]      mem_wr_data,
   input  logic [31:0]      ld_check_addr,
   output logic             ld_addr_hit,
   output logic             full,
   output logic             empty,
   output logic [TAG_W:0]   count,
   output logic             commit_miss
);

   typedef struct packed {
      logic             v;
      logic             c;
      logic [TAG_W-1:0] tag;
      logic [31:0]      addr;
      logic [31:0]      data;
   } ent_t;

   localparam logic [TAG_W:0] PTR_ONE = 1;

   ent_t             q [DEPTH];
   logic [TAG_W:0]   wr_ptr;
   logic [TAG_W:0]   rd_ptr;
   logic [TAG_W-1:0] wr_idx;
   logic [TAG_W-1:0] rd_idx;
   logic [DEPTH-1:0] cmt_hit;
   logic [DEPTH-1:0] cmt_nx;
   logic [DEPTH-1:0] ld_vec;
   logic             any_hit;
   logic             enq;
   logic             enq_cmt;
   logic [TAG_W:0]   keep_len;
   logic             run;
   logic [TAG_W-1:0] scan_idx;

   assign wr_idx   = wr_ptr[TAG_W-1:0];
   assign rd_idx   = rd_ptr[TAG_W-1:0];
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_idx == rd_idx) &&
                     (wr_ptr[TAG_W] != rd_ptr[TAG_W]);
   assign count    = wr_ptr - rd_ptr;
   assign st_ready = ~full;

   // Per-entry commit tag match and load address match
   always_comb begin
      cmt_hit = '0;
      cmt_nx  = '0;
      ld_vec  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cmt_hit[i] = commit_valid & q[i].v & ~q[i].c &
                      (q[i].tag == commit_tag);
         cmt_nx[i]  = q[i].c | cmt_hit[i];
         ld_vec[i]  = q[i].v & (q[i].addr == ld_check_addr);
      end
   end

   assign any_hit     = |cmt_hit;
   assign enq         = st_valid & ~full & ~flush;
   assign enq_cmt     = commit_valid & ~any_hit &
                        (st_tag == commit_tag);
   assign commit_miss = commit_valid & ~any_hit &
                        ~(enq & (st_tag == commit_tag));
   assign ld_addr_hit = |ld_vec;

   assign mem_wr_en   = rst_n & q[rd_idx].v & q[rd_idx].c & ~mem_stall;
   assign mem_wr_addr = mem_wr_en ? q[rd_idx].addr : '0;
   assign mem_wr_data = mem_wr_en ? q[rd_idx].data : '0;

   // Length of the committed prefix starting at the head (commits this cycle included)
   always_comb begin
      keep_len = '0;
      run      = 1'b1;
      scan_idx = rd_idx;
      for (int k = 0; k < DEPTH; k++) begin
         scan_idx = rd_idx + TAG_W'(k);
         if (run && q[scan_idx].v && cmt_nx[scan_idx])
            keep_len = keep_len + PTR_ONE;
         else
            run = 1'b0;
      end
   end

   // Queue state: commit, enqueue, drain, then flush trims the uncommitted tail
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            q[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (cmt_hit[i])
               q[i].c <= 1'b1;
         if (enq) begin
            q[wr_idx].v    <= 1'b1;
            q[wr_idx].c    <= enq_cmt;
            q[wr_idx].tag  <= st_tag;
            q[wr_idx].addr <= st_addr;
            q[wr_idx].data <= st_data;
         end
         if (mem_wr_en) begin
            q[rd_idx].v <= 1'b0;
            q[rd_idx].c <= 1'b0;
            rd_ptr      <= rd_ptr + PTR_ONE;
         end
         if (flush) begin
            for (int i = 0; i < DEPTH; i++)
               if (!cmt_nx[i])
                  q[i].v <= 1'b0;
            wr_ptr <= rd_ptr + keep_len;
         end else if (enq) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
      end
   end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Bench for store_commit_buffer: per-cycle vector table plus
// a drain scoreboard filled at commit time.
module tb_store_commit_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        st_valid;
   logic [3:0]  st_tag;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_ready;
   logic        commit_valid;
   logic [3:0]  commit_tag;
   logic        flush;
   logic        mem_stall;
   logic        mem_wr_en;
   logic [31:0] mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] ld_check_addr;
   logic        ld_addr_hit;
   logic        full;
   logic        empty;
   logic [4:0]  count;
   logic        commit_miss;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        sv;
      logic [3:0]  stag;
      logic [31:0] saddr;
      logic [31:0] sdata;
      logic        cv;
      logic [3:0]  ctag;
      logic        fl;
      logic        stl;
      logic [31:0] ld;
      logic [4:0]  ecnt;
      logic        ewr;
      logic        emiss;
      logic        ehit;
   } vec_t;

   vec_t        tbl [$];
   logic [63:0] sb [$];
   logic [63:0] exp_st [16];

   store_commit_buffer #(.DEPTH(16), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_tag(st_tag),
      .st_addr(st_addr), .st_data(st_data),
      .st_ready(st_ready),
      .commit_valid(commit_valid), .commit_tag(commit_tag),
      .flush(flush), .mem_stall(mem_stall),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data),
      .ld_check_addr(ld_check_addr), .ld_addr_hit(ld_addr_hit),
      .full(full), .empty(empty), .count(count),
      .commit_miss(commit_miss)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drain monitor: each write must match the next committed store
   always @(negedge clk) begin
      if (mem_wr_en) begin
         if (!rst_n)
            chk("wr_in_reset", 64'(mem_wr_en), 64'd0);
         else if (sb.size() == 0)
            chk("unexpected_wr", 64'(mem_wr_en), 64'd0);
         else
            chk("wr_addr_data", {mem_wr_addr, mem_wr_data}, sb.pop_front());
      end
   end

   function automatic vec_t mk(
      input logic sv, input logic [3:0] stag,
      input logic [31:0] saddr, input logic [31:0] sdata,
      input logic cv, input logic [3:0] ctag,
      input logic fl, input logic stl, input logic [31:0] ld,
      input logic [4:0] ecnt, input logic ewr,
      input logic emiss, input logic ehit);
      vec_t t;
      t.sv = sv; t.stag = stag; t.saddr = saddr; t.sdata = sdata;
      t.cv = cv; t.ctag = ctag; t.fl = fl; t.stl = stl; t.ld = ld;
      t.ecnt = ecnt; t.ewr = ewr; t.emiss = emiss; t.ehit = ehit;
      return t;
   endfunction

   task automatic apply(input vec_t t);
      st_valid      = t.sv;
      st_tag        = t.stag;
      st_addr       = t.saddr;
      st_data       = t.sdata;
      commit_valid  = t.cv;
      commit_tag    = t.ctag;
      flush         = t.fl;
      mem_stall     = t.stl;
      ld_check_addr = t.ld;
      if (t.sv && t.ecnt != 5'd16 && !t.fl)
         exp_st[t.stag] = {t.saddr, t.sdata};
      if (t.cv && !t.emiss)
         sb.push_back(exp_st[t.ctag]);
      @(negedge clk);
      chk("count", 64'(count), 64'(t.ecnt));
      chk("full", 64'(full), 64'(t.ecnt == 5'd16));
      chk("st_ready", 64'(st_ready), 64'(t.ecnt != 5'd16));
      chk("empty", 64'(empty), 64'(t.ecnt == 5'd0));
      chk("commit_miss", 64'(commit_miss), 64'(t.emiss));
      chk("ld_addr_hit", 64'(ld_addr_hit), 64'(t.ehit));
      chk("mem_wr_en", 64'(mem_wr_en), 64'(t.ewr));
      if (!t.ewr)
         chk("wr_bus_idle", {mem_wr_addr, mem_wr_data}, 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, count, 0, 0, 0));
      sb.delete();
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      st_valid = 0; st_tag = 0; st_addr = 0; st_data = 0;
      commit_valid = 0; commit_tag = 0; flush = 0;
      mem_stall = 0; ld_check_addr = 0;
      for (int i = 0; i < 16; i++) exp_st[i] = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // basic enqueue / commit / drain
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 3, 'h100, 'hAA, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // commit miss
      tbl.push_back(mk(0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // load address check
      tbl.push_back(mk(1, 0, 'h200, 'h11, 0, 0, 0, 0, 'h200, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h200, 1, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h204, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 'h200, 1, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h200, 1, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h200, 0, 0, 0, 0));
      // same-cycle enqueue+commit, then stall
      tbl.push_back(mk(1, 5, 'h300, 'h33, 1, 5, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // flush keeps committed prefix
      tbl.push_back(mk(1, 1, 'h401, 'hD1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 2, 'h402, 'hD2, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 3, 'h403, 'hD3, 1, 1, 0, 0, 0, 2, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 2, 0, 1, 0, 3, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 'h403, 3, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h403, 2, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 3, 0, 1, 0, 2, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // flush drops same-cycle enqueue, drain proceeds
      tbl.push_back(mk(1, 4, 'h504, 'hD4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 4, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 6, 'h506, 'hD6, 0, 0, 1, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h506, 0, 0, 0, 0));
      // commit wins over same-cycle flush
      tbl.push_back(mk(1, 8, 'h508, 'hD8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 8, 1, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      foreach (tbl[i]) apply(tbl[i]);

      // fill to full, overflow dropped
      for (int i = 0; i < 16; i++)
         apply(mk(1, 4'(i), 32'('h1000 + i), 32'('hF000 + i),
                  0, 0, 0, 0, 0, 5'(i), 0, 0, 0));
      apply(mk(1, 0, 'hDEAD, 'hBEEF, 0, 0, 0, 0, 0, 16, 0, 0, 0));
      apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 'hDEAD, 16, 0, 0, 0));
      apply(mk(1, 0, 'hDEAD, 'hBEEF, 0, 0, 0, 0, 0, 16, 1, 0, 0));
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h1000, 15, 0, 0, 0));
      // enqueue and drain together: count holds
      apply(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 15, 0, 0, 0));
      apply(mk(1, 0, 'h2000, 'h2222, 0, 0, 0, 0, 0, 15, 1, 0, 0));
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h2000, 15, 0, 0, 1));
      // commit four under stall, then reset discards them
      for (int j = 2; j < 6; j++)
         apply(mk(0, 0, 0, 0, 1, 4'(j), 0, 1, 0, 15, 0, 0, 0));
      do_reset();
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h1005, 0, 0, 0, 0));
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h2000, 0, 0, 0, 0));
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
